// File: rtl/fifo_rd_stream_adapter.sv
// Reads a registered-latency FIFO and re-presents its words as a valid/ready stream,
// using a 3-entry skid buffer with credit-based read issue so the buffer can never overflow.
module fifo_rd_stream_adapter #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_underflow,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic [CNT_WIDTH-1:0]  beat_count,
   output logic                  underflow_err,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STOP
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q;
   logic [1:0]            rdPtr_q, rdPtr_d;
   logic [1:0]            wrPtr_q, wrPtr_d;
   logic [FIFO_WIDTH-1:0] buf_q [3];
   logic [CNT_WIDTH-1:0]  beatCount_q, beatCount_d;
   logic                  underflowErr_q, underflowErr_d;
   logic [2:0]            credit;
   logic                  push;
   logic                  pop;

   function automatic logic [1:0] ptrInc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Words already buffered plus the one still on its way both consume a slot.
   assign credit     = {1'b0, occ_q} + {2'b00, inflight_q};
   assign fifo_rd_en = (state_q == RUN) & ~fifo_empty & (credit < 3'd3);

   assign push = inflight_q & ~fifo_underflow;
   assign pop  = m_valid & m_ready;

   assign m_valid       = (occ_q != 2'd0);
   assign m_data        = buf_q[rdPtr_q];
   assign beat_count    = beatCount_q;
   assign underflow_err = underflowErr_q;
   assign busy          = (state_q != IDLE) | (occ_q != 2'd0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = RUN;
         RUN:     if (!en) state_d = STOP;
         STOP: begin
            if (en)               state_d = RUN;
            else if (!inflight_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      occ_d          = occ_q;
      rdPtr_d        = rdPtr_q;
      wrPtr_d        = wrPtr_q;
      beatCount_d    = beatCount_q;
      underflowErr_d = underflowErr_q;
      if (push) wrPtr_d = ptrInc(wrPtr_q);
      if (pop) begin
         rdPtr_d     = ptrInc(rdPtr_q);
         beatCount_d = beatCount_q + CNT_ONE;
      end
      if (push && !pop)      occ_d = occ_q + 2'd1;
      else if (!push && pop) occ_d = occ_q - 2'd1;
      if (inflight_q && fifo_underflow) underflowErr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         occ_q          <= 2'd0;
         inflight_q     <= 1'b0;
         rdPtr_q        <= 2'd0;
         wrPtr_q        <= 2'd0;
         beatCount_q    <= '0;
         underflowErr_q <= 1'b0;
         for (int i = 0; i < 3; i++) buf_q[i] <= '0;
      end else begin
         state_q        <= state_d;
         occ_q          <= occ_d;
         inflight_q     <= fifo_rd_en;
         rdPtr_q        <= rdPtr_d;
         wrPtr_q        <= wrPtr_d;
         beatCount_q    <= beatCount_d;
         underflowErr_q <= underflowErr_d;
         if (push) buf_q[wrPtr_q] <= fifo_data_out;
      end
   end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Self-checking bench: a behavioural FIFO feeds the adapter, and a queue-based
// model of the stream predicts every output on every cycle.
module tb_fifo_rd_stream_adapter;

   localparam int W  = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          m_ready = 1'b0;
   logic          fifoEmpty;
   logic [W-1:0]  fifoDataOut = '0;
   logic          fifoUnderflow = 1'b0;
   logic          fifo_rd_en;
   logic          m_valid;
   logic [W-1:0]  m_data;
   logic [CW-1:0] beat_count;
   logic          underflow_err;
   logic          busy;

   logic [W-1:0]  fifoMem [256];
   int            rdIdx = 0;
   int            wrIdx = 0;
   int            ufIdx = -1;
   logic          fifoClear = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef enum int {M_IDLE, M_RUN, M_STOP} mstate_t;
   mstate_t      mState = M_IDLE;
   logic [W-1:0] bufQ[$];
   int           mInflight = 0;
   int           expBeats = 0;
   logic         expErr = 1'b0;
   int           cycle = 0;
   int           rdCount = 0;
   int           curRun = 0;
   int           lastRun = 0;
   logic [W-1:0] deliveredQ[$];
   int           delivCyc[$];

   fifo_rd_stream_adapter #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifoEmpty),
      .fifo_data_out(fifoDataOut), .fifo_underflow(fifoUnderflow),
      .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .beat_count(beat_count),
      .underflow_err(underflow_err), .busy(busy)
   );

   always #5 clk = ~clk;

   assign fifoEmpty = (rdIdx == wrIdx);

   // Synchronous FIFO with a registered read port; ufIdx marks one word whose read reports underflow.
   always @(posedge clk) begin
      if (fifoClear) begin
         rdIdx         <= wrIdx;
         fifoUnderflow <= 1'b0;
      end else if (fifo_rd_en && !fifoEmpty) begin
         fifoDataOut   <= fifoMem[rdIdx];
         fifoUnderflow <= (rdIdx == ufIdx);
         rdIdx         <= rdIdx + 1;
      end else begin
         fifoUnderflow <= 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Per-cycle compare against the stream model, sampled one time unit before each posedge.
   initial begin
      logic expRdEn;
      forever begin
         @(negedge clk);
         #4;
         cycle++;
         if (!rst_n) begin
            checkOutput("rst_fifo_rd_en", fifo_rd_en, 0);
            checkOutput("rst_m_valid", m_valid, 0);
            checkOutput("rst_m_data", m_data, 0);
            checkOutput("rst_beat_count", beat_count, 0);
            checkOutput("rst_underflow_err", underflow_err, 0);
            checkOutput("rst_busy", busy, 0);
            bufQ.delete();
            mInflight = 0;
            mState    = M_IDLE;
            expBeats  = 0;
            expErr    = 1'b0;
            curRun    = 0;
         end else begin
            expRdEn = (mState == M_RUN) && !fifoEmpty && (bufQ.size() + mInflight < 3);
            checkOutput("fifo_rd_en", fifo_rd_en, expRdEn);
            checkOutput("m_valid", m_valid, bufQ.size() != 0);
            if (bufQ.size() != 0) checkOutput("m_data", m_data, bufQ[0]);
            checkOutput("beat_count", beat_count, expBeats);
            checkOutput("underflow_err", underflow_err, expErr);
            checkOutput("busy", busy, (mState != M_IDLE) || (bufQ.size() != 0));

            if (fifo_rd_en) begin
               rdCount++;
               curRun++;
            end else if (curRun > 0) begin
               lastRun = curRun;
               curRun  = 0;
            end
            if (m_valid && m_ready) begin
               deliveredQ.push_back(m_data);
               delivCyc.push_back(cycle);
            end

            if (bufQ.size() != 0 && m_ready) begin
               void'(bufQ.pop_front());
               expBeats = (expBeats + 1) % (1 << CW);
            end
            if (mInflight != 0) begin
               if (fifoUnderflow) expErr = 1'b1;
               else bufQ.push_back(fifoDataOut);
            end
            case (mState)
               M_IDLE: if (en) mState = M_RUN;
               M_RUN:  if (!en) mState = M_STOP;
               default: begin
                  if (en)                  mState = M_RUN;
                  else if (mInflight == 0) mState = M_IDLE;
               end
            endcase
            mInflight = expRdEn ? 1 : 0;
         end
      end
   end

   task automatic applyStimulus(input logic enVal, input logic readyVal);
      en      = enVal;
      m_ready = readyVal;
   endtask

   task automatic loadWord(input logic [W-1:0] w);
      fifoMem[wrIdx] = w;
      wrIdx++;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic waitDelivered(input int target, input int budget);
      int n = 0;
      while (deliveredQ.size() < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("deliverCount", deliveredQ.size(), target);
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("idleReached", busy, 0);
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0);
      waitCycles(2);
      rst_n = 1'b1;
   endtask

   task automatic checkSequence(input string name, input int base, input int first, input int count);
      for (int k = 0; k < count; k++)
         if (base + k < deliveredQ.size())
            checkOutput(name, deliveredQ[base + k], first + k);
   endtask

   initial begin
      int rBase;
      int dBase;
      waitCycles(3);
      rst_n = 1'b1;

      // Full-rate burst of 8 words
      for (int i = 1; i <= 8; i++) loadWord(W'(i));
      rBase = rdCount;
      dBase = deliveredQ.size();
      applyStimulus(1'b1, 1'b1);
      waitDelivered(dBase + 8, 40);
      waitCycles(2);
      checkOutput("t1_rdCount", rdCount - rBase, 8);
      checkOutput("t1_rdRun", lastRun, 8);
      checkSequence("t1_order", dBase, 1, 8);
      if (deliveredQ.size() >= dBase + 8)
         checkOutput("t1_consecutive", delivCyc[dBase + 7] - delivCyc[dBase], 7);
      checkOutput("t1_beat_count", beat_count, 8);
      applyStimulus(1'b0, 1'b1);
      waitIdle(20);
      resetDut();

      // Back-pressure: buffer fills to 3, then drains in order
      for (int i = 0; i < 8; i++) loadWord(W'(16'h0011 + i));
      rBase = rdCount;
      dBase = deliveredQ.size();
      applyStimulus(1'b1, 1'b0);
      waitCycles(10);
      checkOutput("t2_rdCount", rdCount - rBase, 3);
      checkOutput("t2_rd_en_low", fifo_rd_en, 0);
      checkOutput("t2_m_valid", m_valid, 1);
      applyStimulus(1'b1, 1'b1);
      waitDelivered(dBase + 8, 40);
      checkSequence("t2_order", dBase, 16'h0011, 8);
      checkOutput("t2_rdTotal", rdCount - rBase, 8);
      applyStimulus(1'b0, 1'b1);
      waitIdle(20);
      resetDut();

      // Empty FIFO: nothing happens
      rBase = rdCount;
      applyStimulus(1'b1, 1'b1);
      waitCycles(20);
      checkOutput("t3_rdCount", rdCount - rBase, 0);
      checkOutput("t3_m_valid", m_valid, 0);
      checkOutput("t3_beat_count", beat_count, 0);
      applyStimulus(1'b0, 1'b1);
      waitIdle(20);
      resetDut();

      // en dropped while the 2nd read is being issued
      for (int i = 0; i < 8; i++) loadWord(W'(16'h0021 + i));
      rBase = rdCount;
      dBase = deliveredQ.size();
      applyStimulus(1'b1, 1'b1);
      waitCycles(2);
      applyStimulus(1'b0, 1'b1);
      waitCycles(10);
      checkOutput("t4_rdCount", rdCount - rBase, 2);
      checkOutput("t4_delivered", deliveredQ.size() - dBase, 2);
      checkSequence("t4_order", dBase, 16'h0021, 2);
      checkOutput("t4_busy", busy, 0);
      fifoClear = 1'b1;
      waitCycles(1);
      fifoClear = 1'b0;
      resetDut();

      // Forced underflow on the first read discards that word
      ufIdx = wrIdx;
      for (int i = 0; i < 4; i++) loadWord(W'(16'h0031 + i));
      dBase = deliveredQ.size();
      applyStimulus(1'b1, 1'b1);
      waitCycles(12);
      checkOutput("t5_err", underflow_err, 1);
      checkOutput("t5_delivered", deliveredQ.size() - dBase, 3);
      checkSequence("t5_order", dBase, 16'h0032, 3);
      loadWord(16'h0035);
      loadWord(16'h0036);
      waitCycles(8);
      checkOutput("t5_err_sticky", underflow_err, 1);
      checkSequence("t5_later", dBase + 3, 16'h0035, 2);
      applyStimulus(1'b0, 1'b1);
      waitIdle(20);
      ufIdx = -1;
      resetDut();

      // Reset while occ=2 and one read is in flight
      for (int i = 0; i < 8; i++) loadWord(W'(16'h0041 + i));
      applyStimulus(1'b1, 1'b0);
      waitCycles(4);
      checkOutput("t6_pre_valid", m_valid, 1);
      checkOutput("t6_pre_rd_en", fifo_rd_en, 0);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_async_valid", m_valid, 0);
      checkOutput("t6_async_data", m_data, 0);
      checkOutput("t6_async_busy", busy, 0);
      checkOutput("t6_async_rd_en", fifo_rd_en, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dBase = deliveredQ.size();
      applyStimulus(1'b1, 1'b1);
      waitDelivered(dBase + 5, 40);
      checkSequence("t6_order", dBase, 16'h0044, 5);
      applyStimulus(1'b0, 1'b1);
      waitIdle(20);
      resetDut();

      // Randomized traffic with occasional underflow and en toggling
      for (int i = 0; i < 40; i++) loadWord(W'($urandom));
      ufIdx = wrIdx - 25;
      for (int c = 0; c < 300; c++) begin
         applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0);
         if ($urandom_range(0, 7) == 0) loadWord(W'($urandom));
         @(negedge clk);
      end
      applyStimulus(1'b1, 1'b1);
      waitCycles(150);
      checkOutput("t7_drained", fifoEmpty, 1);
      applyStimulus(1'b0, 1'b1);
      waitIdle(30);
      ufIdx = -1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
